// File: rtl/divide_tokens.sv
// divide_tokens: multi-channel serial token rate divider.
// Each channel passes every Nth '1' token on a[i] to b[i] and drops the rest.
// N (div_q) is shared by all channels and reloaded by a single-cycle load pulse,
// which also clears every channel counter. b is combinational from a.
// Optional feature macro: DIVIDE_TOKENS_DROP_CNT_EN adds saturating per-channel
// dropped-token counters on the drop_cnt port.
module divide_tokens #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 4,
    parameter int DEFAULT_DIV = 2,
    parameter int DROP_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        a,
    input  logic [CNT_W-1:0]           div,
    input  logic                       load,
    output logic [CHANNELS-1:0]        b,
    output logic [CNT_W-1:0]           div_cur
`ifdef DIVIDE_TOKENS_DROP_CNT_EN
    ,
    output logic [CHANNELS*DROP_W-1:0] drop_cnt
`endif
);

    localparam logic [CNT_W-1:0] DIV_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(DEFAULT_DIV);

    // Reject parameter sets the divider cannot represent.
    if (CHANNELS < 1 || CHANNELS > 32 || DEFAULT_DIV < 1 ||
        DEFAULT_DIV >= (1 << CNT_W) || DROP_W < 1) begin : g_param_check
        $error("divide_tokens: parameter out of range");
    end

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_last;

    // A divisor of zero would never pass a token, so it is promoted to one.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DIV_DEFAULT;
        end else if (load) begin
            div_q <= (div == '0) ? DIV_ONE : div;
        end
    end

    // Counter value at which the next token is the Nth one; div_q is never 0.
    assign div_last = div_q - DIV_ONE;
    assign div_cur  = div_q;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [CNT_W-1:0] cnt;
        logic             hit;

        assign hit   = (cnt == div_last);
        assign b[gi] = a[gi] & hit & ~rst;

        // Count tokens modulo div_q; load clears instead of counting its token.
        always_ff @(posedge clk) begin
            if (rst || load) begin
                cnt <= '0;
            end else if (a[gi]) begin
                cnt <= hit ? '0 : cnt + DIV_ONE;
            end
        end

`ifdef DIVIDE_TOKENS_DROP_CNT_EN
        logic [DROP_W-1:0] drop_q;

        // Saturating count of dropped tokens; clear wins over increment on load.
        always_ff @(posedge clk) begin
            if (rst || load) begin
                drop_q <= '0;
            end else if (a[gi] && !hit && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_W'(1);
            end
        end

        assign drop_cnt[gi*DROP_W +: DROP_W] = drop_q;
`endif
    end

endmodule

// File: tb/tb_divide_tokens.sv
// tb_divide_tokens: self-checking bench for divide_tokens.
// A token-counting reference model (token k since reset/load passes when
// k is a multiple of N) predicts b, div_cur and, with
// DIVIDE_TOKENS_DROP_CNT_EN, the saturating drop counters.
module tb_divide_tokens;

    localparam int CH = 4;
    localparam int CW = 4;
    localparam int DD = 2;
    localparam int DW = 2;

    logic          clk;
    logic          rst;
    logic [CH-1:0] a;
    logic [CW-1:0] div;
    logic          load;
    logic [CH-1:0] b;
    logic [CW-1:0] div_cur;
`ifdef DIVIDE_TOKENS_DROP_CNT_EN
    logic [CH*DW-1:0] drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // reference model state
    int n = DD;
    int seen[CH];
    int drops[CH];

    divide_tokens #(
        .CHANNELS(CH), .CNT_W(CW), .DEFAULT_DIV(DD), .DROP_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .a(a), .div(div), .load(load),
        .b(b), .div_cur(div_cur)
`ifdef DIVIDE_TOKENS_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive at negedge, check combinational outputs, advance model.
    task automatic step(input logic [CH-1:0] av, input logic lv,
                        input logic [CW-1:0] dv, input logic rv);
        logic [CH-1:0] exp_b;
        @(negedge clk);
        a = av; load = lv; div = dv; rst = rv;
        #1;
        exp_b = '0;
        for (int i = 0; i < CH; i++) begin
            if (!rv && av[i] && ((seen[i] + 1) % n == 0)) exp_b[i] = 1'b1;
        end
        $display("step a=%b load=%b div=%0d rst=%b b=%b div_cur=%0d",
                 av, lv, dv, rv, b, div_cur);
        checks++;
        assert (b === exp_b) else begin
            errors++;
            $error("FAIL b: got %b expected %b", b, exp_b);
        end
        checks++;
        assert (div_cur === CW'(n)) else begin
            errors++;
            $error("FAIL div_cur: got %0d expected %0d", div_cur, n);
        end
`ifdef DIVIDE_TOKENS_DROP_CNT_EN
        for (int i = 0; i < CH; i++) begin
            checks++;
            assert (drop_cnt[i*DW +: DW] === DW'(drops[i])) else begin
                errors++;
                $error("FAIL drop_cnt[%0d]: got %0d expected %0d",
                       i, drop_cnt[i*DW +: DW], drops[i]);
            end
        end
`endif
        if (rv) begin
            n = DD;
            for (int i = 0; i < CH; i++) begin seen[i] = 0; drops[i] = 0; end
        end else if (lv) begin
            n = (dv == '0) ? 1 : int'(dv);
            for (int i = 0; i < CH; i++) begin seen[i] = 0; drops[i] = 0; end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (av[i]) begin
                    seen[i]++;
                    if (!exp_b[i] && drops[i] < (1 << DW) - 1) drops[i]++;
                end
            end
        end
    endtask

    // Direct check of a single observed bit against a spec-derived constant.
    task automatic check_bit(input string tag, input logic got, input logic want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    initial begin
        logic [15:0] pat_a;
        logic [15:0] pat_b;
        logic [CH-1:0] rav;
        logic [CW-1:0] rdv;
        logic rlv, rrv;

        a = '0; load = 1'b0; div = '0; rst = 1'b1;
        for (int i = 0; i < CH; i++) begin seen[i] = 0; drops[i] = 0; end

        // reset with all tokens present: b must stay low
        step(4'b1111, 1'b0, 4'd0, 1'b1);
        check_bit("rst_b0", b[0], 1'b0);
        step(4'b1111, 1'b0, 4'd0, 1'b1);

        // default N=2 on channel 0
        pat_a = 16'b1100111010001111;
        pat_b = 16'b0100010010000101;
        for (int k = 15; k >= 0; k--) begin
            step({3'b000, pat_a[k]}, 1'b0, 4'd0, 1'b0);
            check_bit("pattern_b0", b[0], pat_b[k]);
        end

        // load 3, then nine tokens on channel 1
        step(4'b0000, 1'b1, 4'd3, 1'b0);
        for (int k = 0; k < 9; k++) begin
            step(4'b0010, 1'b0, 4'd0, 1'b0);
            check_bit("div3_b1", b[1], (k % 3) == 2);
        end

        // load 0 is treated as divisor 1
        step(4'b0000, 1'b1, 4'd0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            rav = CH'($urandom);
            step(rav, 1'b0, 4'd0, 1'b0);
        end
        step(4'b1111, 1'b0, 4'd0, 1'b0);
        check_bit("div1_all_b3", b[3], 1'b1);

        // load cycle uses old state on channel 2
        step(4'b0000, 1'b1, 4'd3, 1'b0);
        step(4'b0100, 1'b0, 4'd0, 1'b0);
        step(4'b0100, 1'b0, 4'd0, 1'b0);
        step(4'b0100, 1'b1, 4'd3, 1'b0);
        check_bit("load_cycle_b2", b[2], 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(4'b0100, 1'b0, 4'd0, 1'b0);
            check_bit("after_load_b2", b[2], k == 2);
        end

        // reset mid-stream
        step(4'b1111, 1'b0, 4'd0, 1'b0);
        step(4'b1111, 1'b1, 4'd5, 1'b1);
        check_bit("rst_mid_b1", b[1], 1'b0);
        step(4'b1111, 1'b0, 4'd0, 1'b0);
        check_bit("post_rst_first_b2", b[2], 1'b0);
        step(4'b1111, 1'b0, 4'd0, 1'b0);
        check_bit("post_rst_second_b2", b[2], 1'b1);

        // back-to-back loads: the last one wins
        step(4'b0000, 1'b1, 4'd7, 1'b0);
        step(4'b0000, 1'b1, 4'd1, 1'b0);
        step(4'b1001, 1'b0, 4'd0, 1'b0);
        check_bit("b2b_load_b0", b[0], 1'b1);

`ifdef DIVIDE_TOKENS_DROP_CNT_EN
        // drop counter saturation and clear
        step(4'b0000, 1'b1, 4'd15, 1'b0);
        for (int k = 0; k < 10; k++) step(4'b0001, 1'b0, 4'd0, 1'b0);
        step(4'b0000, 1'b0, 4'd0, 1'b0);
        check_bit("drop_sat", drop_cnt[1:0] == 2'd3, 1'b1);
        step(4'b0001, 1'b1, 4'd2, 1'b0);
        step(4'b0000, 1'b0, 4'd0, 1'b0);
        check_bit("drop_clear", drop_cnt[1:0] == 2'd0, 1'b1);
`endif

        // randomized traffic with occasional loads and resets
        for (int k = 0; k < 400; k++) begin
            rav = CH'($urandom);
            rlv = ($urandom_range(0, 14) == 0);
            rrv = ($urandom_range(0, 59) == 0);
            rdv = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 4));
            step(rav, rlv, rdv, rrv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
